// File: rtl/snake_game_ctrl.sv
// Game sequencer for the snake datapath: run/pause/over state machine,
// move-tick generation, BCD score and move-period speed-up on food.
module snake_game_ctrl #(
    parameter logic [24:0] BASE_PERIOD = 25'd20000000,
    parameter logic [24:0] MIN_PERIOD  = 25'd5000000,
    parameter logic [24:0] STEP_DEC    = 25'd1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_n,
    input  logic        eat,
    input  logic        hit,
    output logic        step,
    output logic        game_clr,
    output logic [1:0]  state,
    output logic [7:0]  score,
    output logic [24:0] period
);

    localparam int unsigned PW = 25;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2,
        S_OVER  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic            step_q, step_d;
    logic            clr_q, clr_d;
    logic [7:0]      score_q, score_d;
    logic [PW-1:0]   period_q, period_d;
    logic [PW-1:0]   cnt_q, cnt_d;

    logic            start_ev;
    logic            tick;
    logic [7:0]      score_inc;
    logic [PW-1:0]   period_dec;

    assign start_ev = ~start_n;

    // Tick once the count has reached the period; ">=" also catches a period
    // that shrank below the running count after food was eaten.
    assign tick = ((PW+1)'(cnt_q) + (PW+1)'(1)) >= (PW+1)'(period_q);

    // BCD increment of the score, saturating at 99.
    always_comb begin
        score_inc = score_q;
        if (score_q == 8'h99) begin
            score_inc = score_q;
        end else if (score_q[3:0] == 4'd9) begin
            score_inc = {score_q[7:4] + 4'd1, 4'd0};
        end else begin
            score_inc = {score_q[7:4], score_q[3:0] + 4'd1};
        end
    end

    // Period shortened by one step, clamped to the floor without underflow.
    always_comb begin
        if ((PW+1)'(period_q) >= ((PW+1)'(MIN_PERIOD) + (PW+1)'(STEP_DEC))) begin
            period_dec = period_q - STEP_DEC;
        end else begin
            period_dec = MIN_PERIOD;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; collision outranks the pause key while playing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_ev) state_d = S_PLAY;
            end
            S_PLAY: begin
                if (hit) begin
                    state_d = S_OVER;
                end else if (start_ev) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (start_ev) state_d = S_PLAY;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values: game start, scoring, move tick.
    always_comb begin
        step_d   = 1'b0;
        clr_d    = 1'b0;
        score_d  = score_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_ev) begin
                    clr_d    = 1'b1;
                    score_d  = 8'h00;
                    period_d = BASE_PERIOD;
                    cnt_d    = '0;
                end
            end
            S_PLAY: begin
                if (eat) begin
                    score_d  = score_inc;
                    period_d = period_dec;
                end
                if (hit) begin
                    cnt_d = '0;
                end else if (start_ev) begin
                    cnt_d = cnt_q;
                end else if (tick) begin
                    step_d = 1'b1;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + PW'(1);
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Registered outputs and move counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_q   <= 1'b0;
            clr_q    <= 1'b0;
            score_q  <= 8'h00;
            period_q <= BASE_PERIOD;
            cnt_q    <= '0;
        end else begin
            step_q   <= step_d;
            clr_q    <= clr_d;
            score_q  <= score_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
        end
    end

    assign step     = step_q;
    assign game_clr = clr_q;
    assign state    = state_q;
    assign score    = score_q;
    assign period   = period_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Scoreboard bench for snake_game_ctrl with a behavioural game model.
module tb_snake_game_ctrl;

    localparam logic [24:0] BASE = 25'd10;
    localparam logic [24:0] MINP = 25'd4;
    localparam logic [24:0] DEC  = 25'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_n;
    logic        eat;
    logic        hit;
    logic        step;
    logic        game_clr;
    logic [1:0]  state;
    logic [7:0]  score;
    logic [24:0] period;

    always #5 clk = ~clk;

    snake_game_ctrl #(
        .BASE_PERIOD(BASE),
        .MIN_PERIOD (MINP),
        .STEP_DEC   (DEC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_n (start_n),
        .eat     (eat),
        .hit     (hit),
        .step    (step),
        .game_clr(game_clr),
        .state   (state),
        .score   (score),
        .period  (period)
    );

    typedef struct {
        int         due;
        int         st;
        bit         stp;
        bit         clr;
        logic [7:0] sc;
        int         per;
    } exp_t;

    exp_t sbq[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    // Game model: mode 0 idle, 1 play, 2 pause, 3 over; el = cycles since tick.
    int m_mode  = 0;
    int m_score = 0;
    int m_per   = 10;
    int m_el    = 0;
    bit m_step  = 0;
    bit m_clr   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] to_bcd(input int s);
        return 8'((s / 10) * 16 + (s % 10));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, want);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input bit e, input bit h);
        bit due_tick;
        m_step = 0;
        m_clr  = 0;
        if (!r) begin
            m_mode = 0; m_score = 0; m_per = int'(BASE); m_el = 0;
        end else begin
            case (m_mode)
                0, 3: if (!s) begin
                    m_mode = 1; m_clr = 1; m_score = 0; m_per = int'(BASE); m_el = 0;
                end
                1: begin
                    due_tick = (m_el + 1 >= m_per);
                    if (e) begin
                        if (m_score < 99) m_score++;
                        m_per = (m_per - int'(DEC) < int'(MINP)) ? int'(MINP) : m_per - int'(DEC);
                    end
                    if (h) begin
                        m_mode = 3; m_el = 0;
                    end else if (!s) begin
                        m_mode = 2;
                    end else if (due_tick) begin
                        m_step = 1; m_el = 0;
                    end else begin
                        m_el++;
                    end
                end
                default: if (!s) m_mode = 1;
            endcase
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic drive(input bit r, input bit s, input bit e, input bit h);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n = r; start_n = s; eat = e; hit = h;
        model_step(r, s, e, h);
        x.due = cyc + 1;
        x.st  = m_mode;
        x.stp = m_step;
        x.clr = m_clr;
        x.sc  = to_bcd(m_score);
        x.per = m_per;
        sbq.push_back(x);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1, 1, 0, 0);
    endtask

    // Monitor: compare every due expectation against the DUT outputs.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            exp_t x;
            x = sbq.pop_front();
            chk("state",    32'(state),    32'(x.st));
            chk("step",     32'(step),     32'(x.stp));
            chk("game_clr", 32'(game_clr), 32'(x.clr));
            chk("score",    32'(score),    32'(x.sc));
            chk("period",   32'(period),   32'(x.per));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bit r, s, e, h;
        rst_n = 1'b0; start_n = 1'b1; eat = 1'b0; hit = 1'b0;
        repeat (3) drive(0, 1, 0, 0);
        idle(5);

        // Start, free-running steps at the base period.
        drive(1, 0, 0, 0);
        idle(35);

        // Three food events: period drops to the floor.
        repeat (3) begin
            drive(1, 1, 1, 0);
            idle(12);
        end

        // Fresh game, pause with count at 6, noisy pause, resume.
        drive(1, 1, 0, 1);
        drive(1, 0, 0, 0);
        for (int i = 0; i < 20 && m_el != 6; i++) drive(1, 1, 0, 0);
        drive(1, 0, 0, 0);
        repeat (50) drive(1, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drive(1, 0, 0, 0);
        idle(8);

        // Collision exactly on a tick cycle, then restart.
        for (int i = 0; i < 20 && !(m_el + 1 >= m_per); i++) drive(1, 1, 0, 0);
        drive(1, 1, 0, 1);
        idle(15);
        drive(1, 0, 0, 0);
        idle(3);

        // 100 food events: carry into tens and saturation at 99.
        repeat (100) begin
            drive(1, 1, 1, 0);
            drive(1, 1, 0, 0);
        end

        // Reset mid-game.
        idle(5);
        drive(0, 1, 0, 0);
        idle(3);

        // Random play.
        drive(1, 0, 0, 0);
        repeat (3000) begin
            r = ($urandom_range(0, 999) >= 3);
            s = ($urandom_range(0, 99) >= 3);
            e = ($urandom_range(0, 99) < 8);
            h = ($urandom_range(0, 199) < 1);
            drive(r, s, e, h);
        end
        idle(3);

        @(negedge clk);
        @(negedge clk);
        #1;
        chk("drain", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
